// File: rtl/seg7_display_ctrl.sv
// 8-digit multiplexed common-anode 7-segment driver for a 16-bit value,
// shown as 4 hex digits or 5 decimal digits (optionally signed) via double-dabble.
module seg7_display_ctrl #(
    parameter int unsigned COUNT_MAX = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        dec_mode,
    input  logic        dec_signed,
    output logic        conv_done,
    output logic [7:0]  anodes,
    output logic [6:0]  segments,
    output logic        dp
);

    localparam int unsigned CNT_W   = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam int unsigned VAL_W   = 16;
    localparam int unsigned BCD_W   = 20;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned SLOT_N  = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned ITER_W  = 4;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(COUNT_MAX - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VAL_W - 1);
    localparam logic [SEG_W-1:0]  SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0]  SEG_MINUS = 7'h3F;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    function automatic logic [SEG_W-1:0] seg_code(input logic [3:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [1:0]                   state_q,     state_d;
    logic [ITER_W-1:0]            iter_q,      iter_d;
    logic [VAL_W-1:0]             mag_q,       mag_d;
    logic [BCD_W-1:0]             bcd_q,       bcd_d;
    logic [VAL_W-1:0]             shd_value_q, shd_value_d;
    logic                         shd_dec_q,   shd_dec_d;
    logic                         shd_neg_q,   shd_neg_d;
    logic                         conv_done_q, conv_done_d;
    logic [SLOT_N-1:0][SEG_W-1:0] disp_seg_q,  disp_seg_d;
    logic [CNT_W-1:0]             cnt_q,       cnt_d;
    logic [IDX_W-1:0]             idx_q,       idx_d;
    logic [SLOT_N-1:0]            anodes_q,    anodes_d;
    logic [SEG_W-1:0]             segments_q,  segments_d;

    logic                         in_neg_c;
    logic [VAL_W-1:0]             in_mag_c;
    logic [BCD_W-1:0]             bcd_adj_c;
    logic [4:0]                   dec_show_c;

    // 16 bits hold the magnitude: -32768 wraps to 16'h8000, read unsigned as 32768.
    assign in_neg_c = dec_signed & value[15];
    assign in_mag_c = in_neg_c ? (16'd0 - value) : value;

    for (genvar n = 0; n < 5; n++) begin : g_adj
        assign bcd_adj_c[4*n +: 4] = (bcd_q[4*n +: 4] >= 4'd5) ? (bcd_q[4*n +: 4] + 4'd3)
                                                              : bcd_q[4*n +: 4];
    end

    // Leading-zero blanking: a decimal slot shows if it or any higher slot is non-zero.
    assign dec_show_c[4] = (bcd_q[19:16] != 4'd0);
    assign dec_show_c[3] = dec_show_c[4] | (bcd_q[15:12] != 4'd0);
    assign dec_show_c[2] = dec_show_c[3] | (bcd_q[11:8]  != 4'd0);
    assign dec_show_c[1] = dec_show_c[2] | (bcd_q[7:4]   != 4'd0);
    assign dec_show_c[0] = 1'b1;

    // Converter: IDLE sample, 16 shift-add-3 steps, COMMIT digits.
    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        shd_value_d = shd_value_q;
        shd_dec_d   = shd_dec_q;
        shd_neg_d   = shd_neg_q;
        conv_done_d = 1'b0;
        disp_seg_d  = disp_seg_q;

        case (state_q)
            ST_IDLE: begin
                shd_value_d = value;
                shd_dec_d   = dec_mode;
                shd_neg_d   = dec_mode & in_neg_c;
                mag_d       = in_mag_c;
                bcd_d       = '0;
                iter_d      = '0;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_d  = BCD_W'({bcd_adj_c, mag_q[VAL_W-1]});
                mag_d  = {mag_q[VAL_W-2:0], 1'b0};
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_LAST) begin
                    state_d     = ST_COMMIT;
                    conv_done_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                for (int s = 0; s < SLOT_N; s++) begin
                    disp_seg_d[s] = SEG_BLANK;
                end
                if (shd_dec_q) begin
                    for (int s = 0; s < 5; s++) begin
                        if (dec_show_c[s]) begin
                            disp_seg_d[s] = seg_code(bcd_q[4*s +: 4]);
                        end
                    end
                    if (shd_neg_q) begin
                        disp_seg_d[5] = SEG_MINUS;
                    end
                end else begin
                    for (int s = 0; s < 4; s++) begin
                        disp_seg_d[s] = seg_code(shd_value_q[4*s +: 4]);
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Refresh scan; a blank slot keeps every anode and segment off.
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        anodes_d   = 8'hFF;
        segments_d = disp_seg_q[idx_q];
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end
        if (disp_seg_q[idx_q] != SEG_BLANK) begin
            anodes_d = ~(8'd1 << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            iter_q      <= '0;
            mag_q       <= '0;
            bcd_q       <= '0;
            shd_value_q <= '0;
            shd_dec_q   <= 1'b0;
            shd_neg_q   <= 1'b0;
            conv_done_q <= 1'b0;
            disp_seg_q  <= {SLOT_N{SEG_BLANK}};
            cnt_q       <= '0;
            idx_q       <= '0;
            anodes_q    <= 8'hFF;
            segments_q  <= SEG_BLANK;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            shd_value_q <= shd_value_d;
            shd_dec_q   <= shd_dec_d;
            shd_neg_q   <= shd_neg_d;
            conv_done_q <= conv_done_d;
            disp_seg_q  <= disp_seg_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            anodes_q    <= anodes_d;
            segments_q  <= segments_d;
        end
    end

    assign conv_done = conv_done_q;
    assign anodes    = anodes_q;
    assign segments  = segments_q;
    assign dp        = 1'b1;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl: vector table plus scoreboard of committed digit sets,
// checked every cycle against a scan model of the multiplexed outputs.
module tb_seg7_display_ctrl;

    localparam int unsigned COUNT_MAX = 4;
    localparam int unsigned NVEC      = 15;
    localparam logic [6:0]  BL        = 7'h7F;

    typedef logic [7:0][6:0] disp_t;
    typedef struct {
        logic [15:0] value;
        logic        dec_mode;
        logic        dec_signed;
        disp_t       exp;
    } vec_t;

    localparam disp_t DISP_BLANK = {8{7'h7F}};

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        dec_mode;
    logic        dec_signed;
    logic        conv_done;
    logic [7:0]  anodes;
    logic [6:0]  segments;
    logic        dp;

    vec_t  vecs [NVEC];
    disp_t exp_q [$];
    int    n_cmp = 0;
    int    n_err = 0;

    seg7_display_ctrl #(.COUNT_MAX(COUNT_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dec_mode   (dec_mode),
        .dec_signed (dec_signed),
        .conv_done  (conv_done),
        .anodes     (anodes),
        .segments   (segments),
        .dp         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic [15:0] v, input logic dm, input logic ds, input disp_t e);
        vec_t r;
        r.value      = v;
        r.dec_mode   = dm;
        r.dec_signed = ds;
        r.exp        = e;
        return r;
    endfunction

    // Drive inputs for the conversion that samples at the next edge and queue its digits.
    task automatic drive(input logic [15:0] v, input logic dm, input logic ds, input disp_t e);
        value      = v;
        dec_mode   = dm;
        dec_signed = ds;
        exp_q.push_back(e);
    endtask

    task automatic wait_conv_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (conv_done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL conv_done_timeout t=%0t: conv_done stayed 0 for 40 cycles, required a pulse", $time);
        end
    endtask

    // Returns during the IDLE cycle that follows the next commit.
    task automatic next_idle();
        wait_conv_done();
        @(negedge clk);
    endtask

    // Output monitor: scan model + committed-digit model fed from the scoreboard.
    disp_t      m_disp;
    disp_t      m_pend;
    logic [2:0] m_idx;
    int         m_cnt;
    bit         m_commit;
    int         m_since;
    bit         m_first;
    bit         m_missed;
    logic [7:0] e_an;
    logic [6:0] e_seg;

    initial begin
        m_disp   = DISP_BLANK;
        m_pend   = DISP_BLANK;
        m_idx    = '0;
        m_cnt    = 0;
        m_commit = 1'b0;
        m_since  = 0;
        m_first  = 1'b1;
        m_missed = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                e_an  = 8'hFF;
                e_seg = BL;
            end else begin
                e_seg = m_disp[m_idx];
                e_an  = (m_disp[m_idx] != BL) ? ~(8'd1 << m_idx) : 8'hFF;
            end
            n_cmp++;
            if (anodes !== e_an || segments !== e_seg || dp !== 1'b1) begin
                n_err++;
                $display("FAIL scan_out t=%0t: anodes=%h segments=%h dp=%b, required anodes=%h segments=%h dp=1",
                         $time, anodes, segments, dp, e_an, e_seg);
            end
            if (rst) begin
                n_cmp++;
                if (conv_done !== 1'b0) begin
                    n_err++;
                    $display("FAIL conv_done_in_reset t=%0t: conv_done=%b, required 0", $time, conv_done);
                end
                m_disp   = DISP_BLANK;
                m_idx    = '0;
                m_cnt    = 0;
                m_commit = 1'b0;
                m_since  = 0;
                m_first  = 1'b1;
                m_missed = 1'b0;
            end else begin
                if (m_commit) m_disp = m_pend;
                m_commit = 1'b0;
                if (m_cnt == COUNT_MAX - 1) begin
                    m_cnt = 0;
                    m_idx = m_idx + 3'd1;
                end else begin
                    m_cnt++;
                end
                m_since++;
                if (conv_done === 1'b1) begin
                    n_cmp++;
                    if (m_since != (m_first ? 17 : 18)) begin
                        n_err++;
                        $display("FAIL conv_done_spacing t=%0t: pulse after %0d edges, required %0d",
                                 $time, m_since, m_first ? 17 : 18);
                    end
                    m_since  = 0;
                    m_first  = 1'b0;
                    m_missed = 1'b0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL conv_done_unexpected t=%0t: pulse with 0 queued conversions, required at least 1", $time);
                    end else begin
                        m_pend   = exp_q.pop_front();
                        m_commit = 1'b1;
                    end
                end else if (m_since > 18 && !m_missed) begin
                    n_cmp++;
                    n_err++;
                    m_missed = 1'b1;
                    $display("FAIL conv_done_missing t=%0t: %0d edges without pulse, required one every 18", $time, m_since);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        value      = '0;
        dec_mode   = 1'b0;
        dec_signed = 1'b0;

        vecs[0]  = mkv(16'hBEEF, 1'b0, 1'b0, {BL, BL, BL, BL, 7'h03, 7'h06, 7'h06, 7'h0E});
        vecs[1]  = mkv(16'h3039, 1'b1, 1'b0, {BL, BL, BL, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
        vecs[2]  = mkv(16'h8000, 1'b1, 1'b1, {BL, BL, 7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00});
        vecs[3]  = mkv(16'h0000, 1'b1, 1'b1, {BL, BL, BL, BL, BL, BL, BL, 7'h40});
        vecs[4]  = mkv(16'hFFFF, 1'b1, 1'b0, {BL, BL, BL, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12});
        vecs[5]  = mkv(16'hFFFF, 1'b1, 1'b1, {BL, BL, 7'h3F, BL, BL, BL, BL, 7'h79});
        vecs[6]  = mkv(16'h0000, 1'b0, 1'b0, {BL, BL, BL, BL, 7'h40, 7'h40, 7'h40, 7'h40});
        vecs[7]  = mkv(16'h0064, 1'b1, 1'b0, {BL, BL, BL, BL, BL, 7'h79, 7'h40, 7'h40});
        vecs[8]  = mkv(16'h8000, 1'b1, 1'b0, {BL, BL, BL, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00});
        vecs[9]  = mkv(16'hF234, 1'b0, 1'b1, {BL, BL, BL, BL, 7'h0E, 7'h24, 7'h30, 7'h19});
        vecs[10] = mkv(16'h7FFF, 1'b1, 1'b1, {BL, BL, BL, 7'h30, 7'h24, 7'h78, 7'h02, 7'h78});
        vecs[11] = mkv(16'h2710, 1'b1, 1'b0, {BL, BL, BL, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40});
        vecs[12] = mkv(16'hA5C9, 1'b0, 1'b0, {BL, BL, BL, BL, 7'h08, 7'h12, 7'h46, 7'h10});
        vecs[13] = mkv(16'hFFFB, 1'b1, 1'b1, {BL, BL, 7'h3F, BL, BL, BL, BL, 7'h12});
        vecs[14] = mkv(16'h7D80, 1'b0, 1'b0, {BL, BL, BL, BL, 7'h78, 7'h21, 7'h00, 7'h40});

        repeat (3) @(negedge clk);
        drive(vecs[0].value, vecs[0].dec_mode, vecs[0].dec_signed, vecs[0].exp);
        rst = 1'b0;

        // Each vector is held for two conversions so every slot is scanned at least once.
        for (int v = 0; v < NVEC; v++) begin
            for (int rep = 0; rep < 2; rep++) begin
                if (v != 0 || rep != 0) begin
                    next_idle();
                    drive(vecs[v].value, vecs[v].dec_mode, vecs[v].dec_signed, vecs[v].exp);
                end
            end
        end

        // Reset in the middle of SHIFT: that conversion must never commit.
        next_idle();
        drive(16'h1234, 1'b0, 1'b0, {BL, BL, BL, BL, 7'h79, 7'h24, 7'h30, 7'h19});
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);

        // Fresh sample of 7; switching to 9 during SHIFT must not leak into this commit.
        drive(16'd7, 1'b1, 1'b0, {BL, BL, BL, BL, BL, BL, BL, 7'h78});
        rst = 1'b0;
        @(negedge clk);
        value = 16'd9;
        for (int k = 0; k < 3; k++) begin
            next_idle();
            drive(16'd9, 1'b1, 1'b0, {BL, BL, BL, BL, BL, BL, BL, 7'h10});
        end
        wait_conv_done();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d conversions still queued, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
